// File: rtl/psram_qpi_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : psram_qpi_responder_if                                       |
// | Description : PSRAM chip-side pins plus backdoor read port, grouped.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface psram_qpi_responder_if #(
    parameter int MEM_ADDRESS_WIDTH = 10
);
    logic                         chip_enable;
    logic                         sclk;
    logic [3:0]                   sio_in;
    logic [3:0]                   sio_out;
    logic [3:0]                   sio_oe;
    logic                         quad_mode;
    logic                         cmd_error;
    logic [MEM_ADDRESS_WIDTH-1:0] bd_address;
    logic [7:0]                   bd_data;

    // Controller / bench side.
    modport master (
        output chip_enable, sclk, sio_in, bd_address,
        input  sio_out, sio_oe, quad_mode, cmd_error, bd_data
    );

    // Responder side.
    modport slave (
        input  chip_enable, sclk, sio_in, bd_address,
        output sio_out, sio_oe, quad_mode, cmd_error, bd_data
    );
endinterface
`default_nettype wire

// File: rtl/psram_qpi_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : psram_qpi_responder                                          |
// | Description : APS6404-style PSRAM responder: SPI/QPI mode switch, quad     |
// |               write (0x38), fast quad read (0xEB), byte array, backdoor.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module psram_qpi_responder #(
    parameter int MEM_ADDRESS_WIDTH = 10,
    parameter int WAIT_CYCLES       = 6
) (
    input  wire logic             clk,
    input  wire logic             reset,
    psram_qpi_responder_if.slave  bus
);

    localparam int                           DEPTH    = 2 ** MEM_ADDRESS_WIDTH;
    localparam logic [MEM_ADDRESS_WIDTH-1:0] ADDR_ONE = {{(MEM_ADDRESS_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [7:0]                   WAIT_LAST = 8'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_READ   = 3'd4,
        ST_WRITE  = 3'd5,
        ST_IGNORE = 3'd6
    } state_t;

    state_t                       state_q, state_d;
    logic                         sclk_q;
    logic [7:0]                   cnt_q, cnt_d;
    logic [6:0]                   cmd_q, cmd_d;
    logic [MEM_ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic                         is_write_q, is_write_d;
    logic                         phase_q, phase_d;
    logic [3:0]                   hold_q, hold_d;
    logic [3:0]                   sio_out_q, sio_out_d;
    logic [3:0]                   sio_oe_q, sio_oe_d;
    logic                         quad_q, quad_d;
    logic                         cmd_err_q, cmd_err_d;
    logic [7:0]                   bd_data_q;

    logic                         w_rise, w_fall;
    logic [7:0]                   w_cmd;
    logic [7:0]                   w_rd_byte;
    logic                         w_we;
    logic [7:0]                   w_wdata;

    logic [7:0]                   mem [DEPTH];

    assign w_rise    = bus.sclk & ~sclk_q;
    assign w_fall    = ~bus.sclk & sclk_q;
    assign w_cmd     = quad_q ? {cmd_q[3:0], bus.sio_in} : {cmd_q, bus.sio_in[0]};
    assign w_rd_byte = mem[addr_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            // A transaction already under way at reset is never joined mid-stream.
            state_q    <= bus.chip_enable ? ST_IDLE : ST_IGNORE;
            sclk_q     <= 1'b0;
            cnt_q      <= '0;
            cmd_q      <= '0;
            addr_q     <= '0;
            is_write_q <= 1'b0;
            phase_q    <= 1'b0;
            hold_q     <= '0;
            sio_out_q  <= '0;
            sio_oe_q   <= '0;
            quad_q     <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sclk_q     <= bus.sclk;
            cnt_q      <= cnt_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            is_write_q <= is_write_d;
            phase_q    <= phase_d;
            hold_q     <= hold_d;
            sio_out_q  <= sio_out_d;
            sio_oe_q   <= sio_oe_d;
            quad_q     <= quad_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        is_write_d = is_write_q;
        phase_d    = phase_q;
        hold_d     = hold_q;
        sio_out_d  = sio_out_q;
        sio_oe_d   = sio_oe_q;
        quad_d     = quad_q;
        cmd_err_d  = 1'b0;
        w_we       = 1'b0;
        w_wdata    = {hold_q, bus.sio_in};

        // Deselect overrides any sclk edge seen in the same cycle.
        if (bus.chip_enable) begin
            state_d  = ST_IDLE;
            sio_oe_d = 4'h0;
            cnt_d    = '0;
            phase_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_CMD;
                    cnt_d   = '0;
                    phase_d = 1'b0;
                end
                ST_CMD: begin
                    if (w_rise) begin
                        cmd_d = w_cmd[6:0];
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_q == (quad_q ? 8'd1 : 8'd7)) begin
                            cnt_d = '0;
                            if (!quad_q && w_cmd == 8'h35) begin
                                quad_d  = 1'b1;
                                state_d = ST_IGNORE;
                            end else if (quad_q && w_cmd == 8'hF5) begin
                                quad_d  = 1'b0;
                                state_d = ST_IGNORE;
                            end else if (quad_q && w_cmd == 8'hEB) begin
                                is_write_d = 1'b0;
                                state_d    = ST_ADDR;
                            end else if (quad_q && w_cmd == 8'h38) begin
                                is_write_d = 1'b1;
                                state_d    = ST_ADDR;
                            end else begin
                                cmd_err_d = 1'b1;
                                state_d   = ST_IGNORE;
                            end
                        end
                    end
                end
                ST_ADDR: begin
                    if (w_rise) begin
                        // Upper address nibbles shift out the top; only the array index survives.
                        addr_d = {addr_q[MEM_ADDRESS_WIDTH-5:0], bus.sio_in};
                        cnt_d  = cnt_q + 8'd1;
                        if (cnt_q == 8'd5) begin
                            cnt_d = '0;
                            if (is_write_q) begin
                                state_d = ST_WRITE;
                            end else if (WAIT_CYCLES == 0) begin
                                state_d = ST_READ;
                            end else begin
                                state_d = ST_WAIT;
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    if (w_rise) begin
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_q == WAIT_LAST) begin
                            cnt_d   = '0;
                            state_d = ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (w_fall) begin
                        sio_oe_d = 4'hF;
                        phase_d  = ~phase_q;
                        if (!phase_q) begin
                            sio_out_d = w_rd_byte[7:4];
                        end else begin
                            sio_out_d = w_rd_byte[3:0];
                            addr_d    = addr_q + ADDR_ONE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (w_rise) begin
                        phase_d = ~phase_q;
                        if (!phase_q) begin
                            hold_d = bus.sio_in;
                        end else begin
                            w_we   = 1'b1;
                            addr_d = addr_q + ADDR_ONE;
                        end
                    end
                end
                ST_IGNORE: begin
                    state_d = ST_IGNORE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            mem[addr_q] <= w_wdata;
        end
    end

    // Array contents deliberately survive reset; only the read register clears.
    always_ff @(posedge clk) begin
        if (reset) begin
            bd_data_q <= '0;
        end else begin
            bd_data_q <= mem[bus.bd_address];
        end
    end

    assign bus.sio_out   = sio_out_q;
    assign bus.sio_oe    = sio_oe_q;
    assign bus.quad_mode = quad_q;
    assign bus.cmd_error = cmd_err_q;
    assign bus.bd_data   = bd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_psram_qpi_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_psram_qpi_responder                                       |
// | Description : Randomised scoreboard bench with a byte-array memory model.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_psram_qpi_responder;

    localparam int AW    = 10;
    localparam int WAITC = 6;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    psram_qpi_responder_if #(.MEM_ADDRESS_WIDTH(AW)) bus ();

    psram_qpi_responder #(
        .MEM_ADDRESS_WIDTH(AW),
        .WAIT_CYCLES      (WAITC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    int         n_vec  = 0;
    int         n_miss = 0;
    int         err_cycles = 0;
    int         exp_err    = 0;
    logic [7:0] model_mem [DEPTH];
    logic [7:0] wbuf [8];
    logic [3:0] exp_nib [$];
    logic [7:0] exp_bd [$];
    logic [AW-1:0] exp_bd_addr [$];
    logic       bd_req = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares read nibbles at each sclk rise with pins driven, and backdoor reads.
    initial begin
        logic       sclk_prev;
        logic [3:0] en;
        logic [7:0] eb;
        logic [AW-1:0] ea;
        sclk_prev = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (bus.cmd_error === 1'b1) err_cycles++;
            if (bus.sclk && !sclk_prev && bus.sio_oe === 4'hF) begin
                n_vec++;
                if (exp_nib.size() == 0) begin
                    n_miss++;
                    $display("FAIL rd_nibble: got %0h with sio_oe high, no nibble expected", bus.sio_out);
                end else begin
                    en = exp_nib.pop_front();
                    if (bus.sio_out !== en) begin
                        n_miss++;
                        $display("FAIL rd_nibble: got %0h, expected %0h", bus.sio_out, en);
                    end
                end
            end
            if (bd_req) begin
                n_vec++;
                eb = exp_bd.pop_front();
                ea = exp_bd_addr.pop_front();
                if (bus.bd_data !== eb) begin
                    n_miss++;
                    $display("FAIL bd_data[%0h]: got %0h, expected %0h", ea, bus.bd_data, eb);
                end
            end
            sclk_prev = bus.sclk;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
        $fatal(1, "timeout");
    end

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sclk_cycle(input logic [3:0] nib);
        bus.sio_in = nib;
        clk_n(1);
        bus.sclk = 1'b1;
        clk_n(2);
        bus.sclk = 1'b0;
        clk_n(1);
    endtask

    task automatic cs_low();
        bus.chip_enable = 1'b0;
        clk_n(2);
    endtask

    task automatic cs_high();
        clk_n(2);
        bus.chip_enable = 1'b1;
        clk_n(3);
    endtask

    task automatic spi_cmd(input logic [7:0] c);
        for (int i = 7; i >= 0; i--) sclk_cycle({3'b000, c[i]});
    endtask

    task automatic qpi_cmd(input logic [7:0] c);
        sclk_cycle(c[7:4]);
        sclk_cycle(c[3:0]);
    endtask

    task automatic send_addr(input logic [23:0] a);
        for (int i = 5; i >= 0; i--) sclk_cycle(4'((a >> (4 * i)) & 24'hF));
    endtask

    task automatic qpi_write(input logic [23:0] a, input int len);
        cs_low();
        qpi_cmd(8'h38);
        send_addr(a);
        for (int i = 0; i < len; i++) begin
            sclk_cycle(wbuf[i][7:4]);
            sclk_cycle(wbuf[i][3:0]);
            model_mem[(int'(a) + i) % DEPTH] = wbuf[i];
        end
        cs_high();
    endtask

    task automatic qpi_read(input logic [23:0] a, input int len);
        logic [7:0] b;
        for (int i = 0; i < len; i++) begin
            b = model_mem[(int'(a) + i) % DEPTH];
            exp_nib.push_back(b[7:4]);
            exp_nib.push_back(b[3:0]);
        end
        cs_low();
        qpi_cmd(8'hEB);
        send_addr(a);
        repeat (WAITC) sclk_cycle(4'($urandom));
        repeat (2 * len) sclk_cycle(4'h0);
        cs_high();
        check("rd_drain", exp_nib.size(), 0);
        exp_nib.delete();
    endtask

    task automatic bd_check(input int a);
        @(negedge clk);
        bus.bd_address = AW'(a);
        exp_bd.push_back(model_mem[a % DEPTH]);
        exp_bd_addr.push_back(AW'(a));
        bd_req = 1'b1;
        @(negedge clk);
        bd_req = 1'b0;
    endtask

    initial begin
        logic [23:0] a;
        logic [7:0]  c;
        int          len;
        int          e0;

        bus.chip_enable = 1'b1;
        bus.sclk        = 1'b0;
        bus.sio_in      = 4'h0;
        bus.bd_address  = '0;
        reset           = 1'b1;
        clk_n(4);
        check("rst_sio_oe",    bus.sio_oe,    0);
        check("rst_sio_out",   bus.sio_out,   0);
        check("rst_quad_mode", bus.quad_mode, 0);
        check("rst_cmd_error", bus.cmd_error, 0);
        check("rst_bd_data",   bus.bd_data,   0);
        reset = 1'b0;
        clk_n(2);

        // Reset while selected: the in-flight transaction must be ignored.
        bus.chip_enable = 1'b0;
        reset = 1'b1;
        clk_n(3);
        reset = 1'b0;
        spi_cmd(8'h35);
        check("ignore_quad", bus.quad_mode, 0);
        check("ignore_oe",   bus.sio_oe,    0);
        cs_high();
        check("ignore_err",  err_cycles,    0);

        cs_low();
        spi_cmd(8'h35);
        check("spi35_quad", bus.quad_mode, 1);
        check("spi35_oe",   bus.sio_oe,    0);
        cs_high();
        check("spi35_err",  err_cycles,    0);

        wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
        qpi_write(24'h000010, 2);
        bd_check(16'h10);
        bd_check(16'h11);
        qpi_read(24'h000010, 2);

        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        qpi_write(24'hFFF3FF, 2);
        bd_check(16'h3FF);
        bd_check(16'h000);

        // Partial byte then deselect: target keeps 0xA5.
        cs_low();
        qpi_cmd(8'h38);
        send_addr(24'h000010);
        sclk_cycle(4'hF);
        cs_high();
        bd_check(16'h10);

        e0 = err_cycles;
        cs_low();
        qpi_cmd(8'h12);
        cs_high();
        exp_err++;
        check("err12_pulse", err_cycles - e0, 1);
        bd_check(16'h10);
        bd_check(16'h11);

        for (int k = 0; k < 20; k++) begin
            a   = 24'($urandom);
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) wbuf[i] = 8'($urandom);
            qpi_write(a, len);
            qpi_read(a, len);
            bd_check((int'(a) + $urandom_range(0, len - 1)) % DEPTH);
            if (k % 5 == 4) begin
                do c = 8'($urandom); while (c == 8'hF5 || c == 8'hEB || c == 8'h38);
                cs_low();
                qpi_cmd(c);
                cs_high();
                exp_err++;
                check("rand_err_count", err_cycles, exp_err);
            end
        end

        cs_low();
        qpi_cmd(8'hF5);
        check("f5_quad", bus.quad_mode, 0);
        cs_high();

        // Read opcode in SPI mode is unsupported.
        cs_low();
        spi_cmd(8'hEB);
        cs_high();
        exp_err++;
        check("spi_eb_err",  err_cycles,    exp_err);
        check("spi_eb_quad", bus.quad_mode, 0);
        check("spi_eb_oe",   bus.sio_oe,    0);

        clk_n(5);
        check("bd_drain", exp_bd.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
